// File: rtl/logica_pkg.sv
// Shared opcode definitions and per-bit operation for the pipelined logic unit.
// The operation is defined per bit so any operand width reuses the same function.
package logica_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 3'd0,
    OP_OR    = 3'd1,
    OP_XOR   = 3'd2,
    OP_NOT_A = 3'd3,
    OP_NAND  = 3'd4,
    OP_YES   = 3'd5,
    OP_NOR   = 3'd6,
    OP_XNOR  = 3'd7
  } op_logica_t;

  function automatic logic aplicar_op(input logic a, input logic b, input op_logica_t op);
    logic r;
    r = 1'b0;
    case (op)
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_XOR:   r = a ^ b;
      OP_NOT_A: r = ~a;
      OP_NAND:  r = ~(a & b);
      OP_YES:   r = b;
      OP_NOR:   r = ~(a | b);
      OP_XNOR:  r = ~(a ^ b);
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/nucleo_logico.sv
// Combinational bitwise core: applies the selected opcode to every bit pair.
module nucleo_logico
  import logica_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_logica_t       op_i,
  output logic [WIDTH-1:0] res_o
);

  always_comb begin
    res_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      res_o[i] = aplicar_op(a_i[i], b_i[i], op_i);
    end
  end

endmodule

// File: rtl/unidad_logica_pipe.sv
// Two-stage valid/ready logic unit with accumulator feedback and completion counter.
// Define LOGICA_BANDERAS_EN to add registered zero/parity flags alongside salida.
module unidad_logica_pipe
  import logica_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               entrada_valid,
  output logic               entrada_ready,
  input  logic [WIDTH-1:0]   entrada_a,
  input  logic [WIDTH-1:0]   entrada_b,
  input  logic [OP_W-1:0]    op,
  input  logic               acum,
  input  logic               acum_clr,
  output logic               salida_valid,
  input  logic               salida_ready,
  output logic [WIDTH-1:0]   salida,
  output logic [OP_W-1:0]    salida_op,
  output logic [COUNT_W-1:0] cuenta_ops
`ifdef LOGICA_BANDERAS_EN
  ,
  output logic               salida_cero,
  output logic               salida_paridad
`endif
);

  logic               s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]   s1_a_q, s1_a_d;
  logic [WIDTH-1:0]   s1_b_q, s1_b_d;
  logic [OP_W-1:0]    s1_op_q, s1_op_d;
  logic               s1_acum_q, s1_acum_d;

  logic               s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]   s2_res_q, s2_res_d;
  logic [OP_W-1:0]    s2_op_q, s2_op_d;

  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;

  logic               in_hs;
  logic               out_hs;
  logic               s2_load;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   res;

  assign out_hs        = s2_valid_q & salida_ready;
  assign s2_load       = s1_valid_q & (~s2_valid_q | salida_ready);
  assign entrada_ready = ~rst & (~s1_valid_q | s2_load);
  assign in_hs         = entrada_valid & entrada_ready;

  // Accumulate beats read acc as it stands at the S2 load edge (pre-clear value).
  assign op_a = s1_acum_q ? acc_q : s1_a_q;

  nucleo_logico #(
    .WIDTH (WIDTH)
  ) u_nucleo (
    .a_i   (op_a),
    .b_i   (s1_b_q),
    .op_i  (op_logica_t'(s1_op_q)),
    .res_o (res)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_acum_d  = s1_acum_q;
    if (in_hs) begin
      s1_valid_d = 1'b1;
      s1_a_d     = entrada_a;
      s1_b_d     = entrada_b;
      s1_op_d    = op;
      s1_acum_d  = acum;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_op_d    = s2_op_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_res_d   = res;
      s2_op_d    = s1_op_q;
    end else if (out_hs) begin
      s2_valid_d = 1'b0;
    end
  end

  // Clear wins over the load's write-back; the loaded result still goes out.
  always_comb begin
    acc_d = acc_q;
    if (acum_clr) begin
      acc_d = '0;
    end else if (s2_load) begin
      acc_d = res;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_hs) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s1_acum_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_op_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s1_acum_q  <= s1_acum_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_op_q    <= s2_op_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
    end
  end

  assign salida_valid = s2_valid_q;
  assign salida       = s2_res_q;
  assign salida_op    = s2_op_q;
  assign cuenta_ops   = cnt_q;

`ifdef LOGICA_BANDERAS_EN
  logic cero_q, cero_d;
  logic par_q, par_d;

  always_comb begin
    cero_d = cero_q;
    par_d  = par_q;
    if (s2_load) begin
      cero_d = (res == '0);
      par_d  = ^res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cero_q <= 1'b0;
      par_q  <= 1'b0;
    end else begin
      cero_q <= cero_d;
      par_q  <= par_d;
    end
  end

  assign salida_cero    = cero_q;
  assign salida_paridad = par_q;
`endif

endmodule

// File: tb/tb_unidad_logica_pipe.sv
// Scoreboard bench for unidad_logica_pipe (WIDTH=8, COUNT_W=4 to exercise counter wrap).
// Builds with or without LOGICA_BANDERAS_EN; flag checks are compiled in when defined.
module tb_unidad_logica_pipe;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          entrada_valid;
  logic          entrada_ready;
  logic [W-1:0]  entrada_a;
  logic [W-1:0]  entrada_b;
  logic [2:0]    op;
  logic          acum;
  logic          acum_clr;
  logic          salida_valid;
  logic          salida_ready;
  logic [W-1:0]  salida;
  logic [2:0]    salida_op;
  logic [CW-1:0] cuenta_ops;
`ifdef LOGICA_BANDERAS_EN
  logic          salida_cero;
  logic          salida_paridad;
`endif

  unidad_logica_pipe #(.WIDTH(W), .COUNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .entrada_valid (entrada_valid),
    .entrada_ready (entrada_ready),
    .entrada_a     (entrada_a),
    .entrada_b     (entrada_b),
    .op            (op),
    .acum          (acum),
    .acum_clr      (acum_clr),
    .salida_valid  (salida_valid),
    .salida_ready  (salida_ready),
    .salida        (salida),
    .salida_op     (salida_op),
    .cuenta_ops    (cuenta_ops)
`ifdef LOGICA_BANDERAS_EN
    ,
    .salida_cero   (salida_cero),
    .salida_paridad(salida_paridad)
`endif
  );

  typedef struct {
    logic [W-1:0] res;
    logic [2:0]   op;
  } exp_t;

  exp_t sb[$];
  int   hs_q[$];
  int   out_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  logic         hold_chk = 1'b0;
  logic [W-1:0] hold_res;
  logic [2:0]   hold_op;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [2:0] o);
    case (o)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~a;
      3'd4:    return ~(a & b);
      3'd5:    return b;
      3'd6:    return ~(a | b);
      default: return ~(a ^ b);
    endcase
  endfunction

  // Output monitor: hold stability while stalled, then pop and compare on each handshake.
  always @(negedge clk) begin
    if (rst) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        n_vec++;
        if (salida_valid !== 1'b1 || salida !== hold_res || salida_op !== hold_op) begin
          n_err++;
          $display("FAIL hold: valid=%b salida=%h op=%0d, required valid=1 salida=%h op=%0d",
                   salida_valid, salida, salida_op, hold_res, hold_op);
        end
      end
      hold_chk = 1'b0;
      if (salida_valid === 1'b1 && salida_ready === 1'b1) begin
        out_q.push_back(cyc);
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output: salida=%h op=%0d, required no output", salida, salida_op);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (salida !== e.res || salida_op !== e.op) begin
            n_err++;
            $display("FAIL result: salida=%h op=%0d, required salida=%h op=%0d",
                     salida, salida_op, e.res, e.op);
          end
`ifdef LOGICA_BANDERAS_EN
          n_vec++;
          if (salida_cero !== (e.res == '0) || salida_paridad !== ^e.res) begin
            n_err++;
            $display("FAIL flags: cero=%b par=%b, required cero=%b par=%b",
                     salida_cero, salida_paridad, (e.res == '0), ^e.res);
          end
`endif
        end
      end else if (salida_valid === 1'b1) begin
        hold_chk = 1'b1;
        hold_res = salida;
        hold_op  = salida_op;
      end
    end
  end

  task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o,
                           input logic ac, input logic [W-1:0] expv);
    bit done = 0;
    int waited = 0;
    int c = 0;
    entrada_valid = 1'b1;
    entrada_a = a;
    entrada_b = b;
    op = o;
    acum = ac;
    while (!done) begin
      @(negedge clk);
      done = entrada_ready;
      c = cyc;
      @(posedge clk);
      #1;
      if (!done) begin
        waited++;
        if (waited > 200) begin
          n_vec++;
          n_err++;
          $display("FAIL send_timeout: entrada_ready=%b, required 1 within 200 cycles", entrada_ready);
          entrada_valid = 1'b0;
          return;
        end
      end
    end
    sb.push_back('{res: expv, op: o});
    hs_q.push_back(c);
    entrada_valid = 1'b0;
  endtask

  task automatic drain();
    int i = 0;
    while (sb.size() != 0 && i < 60) begin
      @(negedge clk);
      i++;
    end
    @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (entrada_ready !== 1'b0 || salida_valid !== 1'b0 || salida !== 8'h00 ||
        salida_op !== 3'd0 || cuenta_ops !== 4'd0) begin
      n_err++;
      $display("FAIL reset_state: rdy=%b vld=%b salida=%h op=%0d cnt=%0d, required 0 0 00 0 0",
               entrada_ready, salida_valid, salida, salida_op, cuenta_ops);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (entrada_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_reset: entrada_ready=%b, required 1", entrada_ready);
    end
    @(posedge clk);
    #1;
    // acc starts at zero, so an accumulate OR passes B through
    send_beat(8'hAA, 8'h5A, 3'd1, 1'b1, 8'h5A);
    drain();
  endtask

  task automatic test_stream();
    logic [W-1:0] tbl [8];
    logic [CW-1:0] c0;
    tbl = '{8'h30, 8'hFC, 8'hCC, 8'h0F, 8'hCF, 8'h3C, 8'h03, 8'h33};
    apply_reset();
    salida_ready = 1'b1;
    hs_q.delete();
    out_q.delete();
    c0 = cuenta_ops;
    for (int i = 0; i < 8; i++) send_beat(8'hF0, 8'h3C, 3'(i), 1'b0, tbl[i]);
    drain();
    n_vec++;
    if (hs_q.size() != 8 || out_q.size() != 8) begin
      n_err++;
      $display("FAIL stream_count: hs=%0d out=%0d, required 8 8", hs_q.size(), out_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_vec++;
        if (out_q[i] != hs_q[i] + 2 || out_q[i] != out_q[0] + i) begin
          n_err++;
          $display("FAIL latency[%0d]: out cycle %0d, required %0d", i, out_q[i], hs_q[0] + 2 + i);
        end
      end
    end
    n_vec++;
    if (cuenta_ops !== CW'(c0 + 8)) begin
      n_err++;
      $display("FAIL stream_cuenta: cuenta_ops=%0d, required %0d", cuenta_ops, CW'(c0 + 8));
    end
  endtask

  task automatic test_backpressure();
    logic [CW-1:0] c0;
    c0 = cuenta_ops;
    salida_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) send_beat(8'hF0, 8'h3C, 3'(i), 1'b0, model_op(8'hF0, 8'h3C, 3'(i)));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        salida_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (entrada_ready !== 1'b0) begin
          n_err++;
          $display("FAIL stall_ready: entrada_ready=%b, required 0", entrada_ready);
        end
        repeat (4) @(posedge clk);
        #1;
        salida_ready = 1'b1;
      end
    join
    drain();
    n_vec++;
    if (cuenta_ops !== CW'(c0 + 8)) begin
      n_err++;
      $display("FAIL stall_cuenta: cuenta_ops=%0d, required %0d", cuenta_ops, CW'(c0 + 8));
    end
  endtask

  task automatic test_accumulate();
    salida_ready = 1'b1;
    acum_clr = 1'b1;
    @(posedge clk);
    #1;
    acum_clr = 1'b0;
    send_beat(8'($urandom), 8'h01, 3'd1, 1'b1, 8'h01);
    send_beat(8'($urandom), 8'h02, 3'd1, 1'b1, 8'h03);
    send_beat(8'($urandom), 8'h03, 3'd2, 1'b1, 8'h00);
    send_beat(8'h00, 8'h07, 3'd5, 1'b0, 8'h07);
    drain();
  endtask

  task automatic test_acum_clr();
    salida_ready = 1'b1;
    send_beat(8'h00, 8'h55, 3'd5, 1'b0, 8'h55);
    // clear lands on the same edge this beat moves into S2
    send_beat(8'h12, 8'hFF, 3'd0, 1'b1, 8'h55);
    acum_clr = 1'b1;
    @(posedge clk);
    #1;
    acum_clr = 1'b0;
    send_beat(8'h12, 8'h0A, 3'd1, 1'b1, 8'h0A);
    drain();
  endtask

  task automatic test_reset_mid();
    salida_ready = 1'b0;
    send_beat(8'h11, 8'h22, 3'd1, 1'b0, 8'h33);
    send_beat(8'h11, 8'h22, 3'd2, 1'b0, 8'h33);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    n_vec++;
    if (entrada_ready !== 1'b0) begin
      n_err++;
      $display("FAIL ready_in_reset: entrada_ready=%b, required 0", entrada_ready);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (salida_valid !== 1'b0 || cuenta_ops !== 4'd0) begin
      n_err++;
      $display("FAIL reset_flush: valid=%b cuenta=%0d, required 0 0", salida_valid, cuenta_ops);
    end
    salida_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_vec++;
    if (cuenta_ops !== 4'd0) begin
      n_err++;
      $display("FAIL stale_output: cuenta_ops=%0d, required 0", cuenta_ops);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] macc, a, b, r;
    logic [2:0] o;
    logic ac;
    bit run = 1;
    salida_ready = 1'b1;
    acum_clr = 1'b1;
    @(posedge clk);
    #1;
    acum_clr = 1'b0;
    macc = '0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          a = 8'($urandom);
          b = 8'($urandom);
          o = 3'($urandom_range(0, 7));
          ac = 1'($urandom_range(0, 1));
          r = model_op(ac ? macc : a, b, o);
          macc = r;
          send_beat(a, b, o, ac, r);
        end
        run = 0;
      end
      begin
        while (run) begin
          @(posedge clk);
          #1;
          salida_ready = 1'($urandom_range(0, 1));
        end
        salida_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_wrap();
    apply_reset();
    salida_ready = 1'b1;
    for (int i = 0; i < 17; i++) send_beat(8'(i), 8'hC3, 3'd2, 1'b0, model_op(8'(i), 8'hC3, 3'd2));
    drain();
    n_vec++;
    if (cuenta_ops !== 4'd1) begin
      n_err++;
      $display("FAIL cuenta_wrap: cuenta_ops=%0d, required 1", cuenta_ops);
    end
  endtask

  initial begin
    rst = 1'b1;
    entrada_valid = 1'b0;
    entrada_a = '0;
    entrada_b = '0;
    op = '0;
    acum = 1'b0;
    acum_clr = 1'b0;
    salida_ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_accumulate();
    test_acum_clr();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
